// File: rtl/ctl_pipe_reg.sv
// Control-bundle pipeline register: DEPTH stages with per-stage flush, global stall and a registered occupancy count.
// Optional statistics counters (stall_cnt, bubble_cnt) are built when CTL_PIPE_STATS_EN is defined.
module ctl_pipe_reg #(
  parameter int WIDTH = 10,  // 1..64
  parameter int DEPTH = 1    // 1..4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_ctl,
  input  logic             stall,
  input  logic [DEPTH-1:0] flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_ctl,
  output logic [2:0]       occupancy
`ifdef CTL_PIPE_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      bubble_cnt
`endif
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] ctl_q [DEPTH];
  logic [WIDTH-1:0] ctl_d [DEPTH];
  logic [2:0]       occ_d;

  // Flush beats stall, and a flushed stage still hands its old contents forward.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    valid_d = valid_q;
    for (int k = 0; k < DEPTH; k++) ctl_d[k] = ctl_q[k];

    if (flush[0]) begin
      valid_d[0] = 1'b0;
      ctl_d[0]   = '0;
    end else if (!stall) begin
      valid_d[0] = in_valid;
      ctl_d[0]   = in_valid ? in_ctl : '0;
    end

    for (int k = 1; k < DEPTH; k++) begin
      if (flush[k]) begin
        valid_d[k] = 1'b0;
        ctl_d[k]   = '0;
      end else if (!stall) begin
        valid_d[k] = valid_q[k-1];
        ctl_d[k]   = ctl_q[k-1];
      end
    end

    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) occ_d = occ_d + 3'(valid_d[k]);
  end

  // NOTE: the stage array is tiny control state, so it is reset like ordinary flops;
  // bubbles must read as all-zero controls straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      for (int k = 0; k < DEPTH; k++) ctl_q[k] <= '0;
      occupancy <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all stages shift in lockstep.
      valid_q   <= valid_d;
      for (int k = 0; k < DEPTH; k++) ctl_q[k] <= ctl_d[k];
      occupancy <= occ_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_ctl   = ctl_q[DEPTH-1];

`ifdef CTL_PIPE_STATS_EN
  // Saturating counters; a bubble is an unstalled edge with an empty output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (!stall && !valid_q[DEPTH-1] && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule
